// File: rtl/az_sequencer.sv
// Auto-zero measurement sequencer: steers the input mux, waits for settling,
// fires the ADC trig and collects the valid handshake, alternating HI/LO phases.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | mux parked on LO, waiting for run
// SETTLE    | mux driven to current phase, settle counter running
// TRIG      | one-cycle start pulse to the ADC, timeout counter loaded
// WAIT_LOW  | waiting for the ADC to drop valid (trig acknowledged)
// WAIT_HIGH | waiting for the ADC to raise valid (conversion done)
// DONE      | completion reported, next phase chosen
module az_sequencer #(
  parameter int CNT_W        = 32,
  parameter int SAMPLE_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    run,
  input  logic                    az_enable,
  input  logic [CNT_W-1:0]        clk_settle_duration,
  input  logic [CNT_W-1:0]        clk_timeout_duration,
  input  logic                    adc_measure_valid,
  output logic                    adc_measure_trig,
  output logic                    azmux_hi,
  output logic                    phase_valid,
  output logic                    phase_hi,
  output logic [SAMPLE_CNT_W-1:0] sample_count,
  output logic                    timeout_err,
  output logic [5:0]              monitor
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETTLE    = 3'd1,
    S_TRIG      = 3'd2,
    S_WAIT_LOW  = 3'd3,
    S_WAIT_HIGH = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic             phase;
  logic [CNT_W-1:0] settle_cnt;
  logic [CNT_W-1:0] to_cnt;
  logic             to_en;
  logic             valid_q;
  logic             to_expire;
  logic             next_phase;

  // Expiry fires on the wait clock whose decrement would reach zero.
  assign to_expire = to_en && (to_cnt == CNT_ONE);

  always_comb begin
    next_phase = 1'b1;
    if (az_enable) next_phase = ~phase;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      phase            <= 1'b1;
      settle_cnt       <= '0;
      to_cnt           <= '0;
      to_en            <= 1'b0;
      valid_q          <= 1'b0;
      adc_measure_trig <= 1'b0;
      azmux_hi         <= 1'b0;
      phase_valid      <= 1'b0;
      phase_hi         <= 1'b0;
      sample_count     <= '0;
      timeout_err      <= 1'b0;
    end else begin
      adc_measure_trig <= 1'b0;
      phase_valid      <= 1'b0;
      valid_q          <= adc_measure_valid;
      case (state)
        S_IDLE: begin
          azmux_hi <= 1'b0;
          if (run) begin
            state       <= S_SETTLE;
            phase       <= 1'b1;
            timeout_err <= 1'b0;
            settle_cnt  <= clk_settle_duration;
            azmux_hi    <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (!run) begin
            state    <= S_IDLE;
            azmux_hi <= 1'b0;
          end else if (settle_cnt == '0) begin
            state            <= S_TRIG;
            adc_measure_trig <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        S_TRIG: begin
          if (!run) begin
            state    <= S_IDLE;
            azmux_hi <= 1'b0;
          end else begin
            to_cnt <= clk_timeout_duration;
            to_en  <= |clk_timeout_duration;
            state  <= S_WAIT_LOW;
          end
        end
        S_WAIT_LOW: begin
          if (!run) begin
            state    <= S_IDLE;
            azmux_hi <= 1'b0;
          end else if (to_expire) begin
            state       <= S_IDLE;
            azmux_hi    <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            if (to_en) to_cnt <= to_cnt - 1'b1;
            if (!adc_measure_valid) state <= S_WAIT_HIGH;
          end
        end
        S_WAIT_HIGH: begin
          // abort beats valid, valid beats timeout
          if (!run) begin
            state    <= S_IDLE;
            azmux_hi <= 1'b0;
          end else if (adc_measure_valid) begin
            state        <= S_DONE;
            phase_valid  <= 1'b1;
            phase_hi     <= phase;
            sample_count <= sample_count + 1'b1;
          end else if (to_expire) begin
            state       <= S_IDLE;
            azmux_hi    <= 1'b0;
            timeout_err <= 1'b1;
          end else if (to_en) begin
            to_cnt <= to_cnt - 1'b1;
          end
        end
        S_DONE: begin
          phase <= next_phase;
          if (run) begin
            state      <= S_SETTLE;
            settle_cnt <= clk_settle_duration;
            azmux_hi   <= next_phase;
          end else begin
            state    <= S_IDLE;
            azmux_hi <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          azmux_hi <= 1'b0;
        end
      endcase
    end
  end

  assign monitor = {state[1:0], phase_valid, azmux_hi, valid_q, adc_measure_trig};

endmodule

// File: tb/tb_az_sequencer.sv
// Self-checking bench for az_sequencer: ADC mock plus a cycle-level scoreboard
// of trig/valid/phase events compared against expectations from the rules.
module tb_az_sequencer;
  localparam int CNT_W = 32;
  localparam int SCW   = 8;
  localparam int SCMOD = 1 << SCW;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             run;
  logic             az_enable;
  logic [CNT_W-1:0] clk_settle_duration;
  logic [CNT_W-1:0] clk_timeout_duration;
  logic             adc_measure_valid;
  logic             adc_measure_trig;
  logic             azmux_hi;
  logic             phase_valid;
  logic             phase_hi;
  logic [SCW-1:0]   sample_count;
  logic             timeout_err;
  logic [5:0]       monitor;

  always #5 clk = ~clk;

  az_sequencer #(.CNT_W(CNT_W), .SAMPLE_CNT_W(SCW)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .run                  (run),
    .az_enable            (az_enable),
    .clk_settle_duration  (clk_settle_duration),
    .clk_timeout_duration (clk_timeout_duration),
    .adc_measure_valid    (adc_measure_valid),
    .adc_measure_trig     (adc_measure_trig),
    .azmux_hi             (azmux_hi),
    .phase_valid          (phase_valid),
    .phase_hi             (phase_hi),
    .sample_count         (sample_count),
    .timeout_err          (timeout_err),
    .monitor              (monitor)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int sc_model = 0;

  int mock_dur   = 5;
  int mock_stale = 0;
  bit mock_never = 1'b0;
  int mock_hold;
  int mock_left;
  bit mock_busy;

  // ADC mock: drops valid after a trig (optionally late), raises it mock_dur clocks later
  initial begin
    adc_measure_valid = 1'b0;
    mock_busy = 1'b0;
    mock_hold = 0;
    mock_left = 0;
    forever begin
      @(negedge clk);
      if (adc_measure_trig) begin
        mock_busy = 1'b1;
        mock_hold = mock_stale;
        mock_left = mock_dur;
        if (mock_hold == 0) adc_measure_valid = 1'b0;
      end else if (mock_busy) begin
        if (mock_hold > 0) begin
          mock_hold--;
          if (mock_hold == 0) adc_measure_valid = 1'b0;
        end else if (!mock_never) begin
          mock_left--;
          if (mock_left == 0) begin
            adc_measure_valid = 1'b1;
            mock_busy = 1'b0;
          end
        end
      end
    end
  end

  int e_cyc [16];
  int t_cyc [16];
  int v_cyc [16];
  int tcnt  [16];
  int ph    [16];
  int sc    [16];
  int mux_t [16];
  int got;
  int mux_bad;
  int width_bad;

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Records per-phase event times; phase i starts at its SETTLE entry cycle.
  task automatic collect(input int n, input int budget);
    bit prev_pv;
    bit prev_mux;
    int run_w;
    got = 0; mux_bad = 0; width_bad = 0; run_w = 0;
    prev_pv = 1'b0;
    prev_mux = azmux_hi;
    for (int c = 0; c < budget && got < n; c++) begin
      step(1);
      if (c == 0 || prev_pv) begin
        e_cyc[got] = cyc; tcnt[got] = 0; t_cyc[got] = -1000; mux_t[got] = -1;
      end else if (azmux_hi !== prev_mux) begin
        mux_bad++;
      end
      if (adc_measure_trig) begin
        if (tcnt[got] == 0) begin
          t_cyc[got] = cyc;
          mux_t[got] = int'(azmux_hi);
        end
        tcnt[got]++;
        run_w++;
        if (run_w > 1) width_bad++;
      end else begin
        run_w = 0;
      end
      if (phase_valid) begin
        v_cyc[got] = cyc;
        ph[got] = int'(phase_hi);
        sc[got] = int'(sample_count);
        got++;
      end
      prev_pv = phase_valid;
      prev_mux = azmux_hi;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; run = 1'b0; az_enable = 1'b0;
    clk_settle_duration = '0; clk_timeout_duration = '0;
    step(3);
    reset_n = 1'b1;
    step(2);
    checks++; if (adc_measure_trig !== 1'b0) begin fails++; $display("FAIL reset_trig: got %b want 0", adc_measure_trig); end
    checks++; if (azmux_hi !== 1'b0) begin fails++; $display("FAIL reset_azmux: got %b want 0", azmux_hi); end
    checks++; if (phase_valid !== 1'b0) begin fails++; $display("FAIL reset_phase_valid: got %b want 0", phase_valid); end
    checks++; if (phase_hi !== 1'b0) begin fails++; $display("FAIL reset_phase_hi: got %b want 0", phase_hi); end
    checks++; if (sample_count !== '0) begin fails++; $display("FAIL reset_sample_count: got %0d want 0", sample_count); end
    checks++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    sc_model = 0;
  endtask

  task automatic test_hi_only();
    int s, d;
    az_enable = 1'b0; clk_timeout_duration = '0; mock_stale = 0; mock_never = 1'b0;
    for (int it = 0; it < 3; it++) begin
      s = (it == 0) ? 3 : int'($urandom_range(0, 6));
      d = (it == 0) ? 10 : int'($urandom_range(3, 12));
      clk_settle_duration = CNT_W'(s); mock_dur = d;
      run = 1'b1;
      collect(3, 300);
      run = 1'b0;
      checks++; if (got !== 3) begin fails++; $display("FAIL hi_only_completions: got %0d want 3", got); end
      for (int i = 0; i < got; i++) begin
        sc_model = (sc_model + 1) % SCMOD;
        checks++; if (ph[i] !== 1) begin fails++; $display("FAIL hi_only_phase_hi[%0d]: got %0d want 1", i, ph[i]); end
        checks++; if (sc[i] !== sc_model) begin fails++; $display("FAIL hi_only_count[%0d]: got %0d want %0d", i, sc[i], sc_model); end
        checks++; if (t_cyc[i] - e_cyc[i] !== s + 1) begin fails++; $display("FAIL hi_only_settle[%0d]: got %0d want %0d", i, t_cyc[i] - e_cyc[i], s + 1); end
        checks++; if (v_cyc[i] - t_cyc[i] !== d + 1) begin fails++; $display("FAIL hi_only_latency[%0d]: got %0d want %0d", i, v_cyc[i] - t_cyc[i], d + 1); end
        checks++; if (tcnt[i] !== 1) begin fails++; $display("FAIL hi_only_trig_count[%0d]: got %0d want 1", i, tcnt[i]); end
        checks++; if (mux_t[i] !== 1) begin fails++; $display("FAIL hi_only_mux[%0d]: got %0d want 1", i, mux_t[i]); end
      end
      checks++; if (width_bad !== 0) begin fails++; $display("FAIL hi_only_trig_width: got %0d long pulses want 0", width_bad); end
      checks++; if (mux_bad !== 0) begin fails++; $display("FAIL hi_only_mux_stable: got %0d changes want 0", mux_bad); end
      step(2);
      checks++; if (azmux_hi !== 1'b0) begin fails++; $display("FAIL hi_only_idle_mux: got %b want 0", azmux_hi); end
    end
  endtask

  task automatic test_auto_zero();
    int s, exp_ph;
    az_enable = 1'b1; clk_timeout_duration = '0; mock_stale = 0; mock_never = 1'b0;
    for (int it = 0; it < 2; it++) begin
      s = (it == 0) ? 0 : int'($urandom_range(1, 5));
      clk_settle_duration = CNT_W'(s); mock_dur = int'($urandom_range(3, 8));
      run = 1'b1;
      collect(4, 300);
      run = 1'b0;
      checks++; if (got !== 4) begin fails++; $display("FAIL az_completions: got %0d want 4", got); end
      for (int i = 0; i < got; i++) begin
        sc_model = (sc_model + 1) % SCMOD;
        exp_ph = (i % 2 == 0) ? 1 : 0;
        checks++; if (ph[i] !== exp_ph) begin fails++; $display("FAIL az_phase_hi[%0d]: got %0d want %0d", i, ph[i], exp_ph); end
        checks++; if (mux_t[i] !== exp_ph) begin fails++; $display("FAIL az_mux_at_trig[%0d]: got %0d want %0d", i, mux_t[i], exp_ph); end
        checks++; if (tcnt[i] !== 1) begin fails++; $display("FAIL az_trig_count[%0d]: got %0d want 1", i, tcnt[i]); end
        checks++; if (sc[i] !== sc_model) begin fails++; $display("FAIL az_count[%0d]: got %0d want %0d", i, sc[i], sc_model); end
        checks++; if (t_cyc[i] - e_cyc[i] !== s + 1) begin fails++; $display("FAIL az_settle[%0d]: got %0d want %0d", i, t_cyc[i] - e_cyc[i], s + 1); end
      end
      checks++; if (mux_bad !== 0) begin fails++; $display("FAIL az_mux_changes: got %0d off-entry changes want 0", mux_bad); end
      step(2);
    end
  endtask

  task automatic test_stale_valid();
    int d;
    az_enable = 1'b0; clk_timeout_duration = '0; mock_never = 1'b0;
    mock_stale = 2; d = int'($urandom_range(3, 8)); mock_dur = d;
    clk_settle_duration = CNT_W'(1);
    run = 1'b1;
    collect(3, 300);
    run = 1'b0;
    checks++; if (got !== 3) begin fails++; $display("FAIL stale_completions: got %0d want 3", got); end
    for (int i = 0; i < got; i++) begin
      sc_model = (sc_model + 1) % SCMOD;
      checks++; if (v_cyc[i] - t_cyc[i] !== 2 + d + 1) begin fails++; $display("FAIL stale_latency[%0d]: got %0d want %0d", i, v_cyc[i] - t_cyc[i], 3 + d); end
      checks++; if (sc[i] !== sc_model) begin fails++; $display("FAIL stale_count[%0d]: got %0d want %0d", i, sc[i], sc_model); end
    end
    mock_stale = 0;
    step(2);
  endtask

  task automatic test_timeout();
    int tc, ec, pvs;
    bit seen;
    tc = -1000; ec = 0; pvs = 0; seen = 1'b0;
    az_enable = 1'b0; mock_never = 1'b1; mock_dur = 5;
    clk_settle_duration = CNT_W'($urandom_range(0, 4));
    clk_timeout_duration = CNT_W'(20);
    run = 1'b1;
    for (int c = 0; c < 300 && !seen; c++) begin
      step(1);
      if (adc_measure_trig && tc < 0) tc = cyc;
      if (phase_valid) pvs++;
      if (timeout_err) begin seen = 1'b1; ec = cyc; end
    end
    run = 1'b0;
    checks++; if (seen !== 1'b1) begin fails++; $display("FAIL timeout_seen: got %b want 1", seen); end
    checks++; if (ec - tc !== 21) begin fails++; $display("FAIL timeout_delay: got %0d want 21", ec - tc); end
    checks++; if (pvs !== 0) begin fails++; $display("FAIL timeout_no_phase_valid: got %0d want 0", pvs); end
    checks++; if (int'(sample_count) !== sc_model) begin fails++; $display("FAIL timeout_count: got %0d want %0d", sample_count, sc_model); end
    checks++; if (azmux_hi !== 1'b0) begin fails++; $display("FAIL timeout_idle_mux: got %b want 0", azmux_hi); end
    step(3);
    checks++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL timeout_sticky: got %b want 1", timeout_err); end
    clk_timeout_duration = '0;
    run = 1'b1;
    step(1);
    checks++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL timeout_clear: got %b want 0", timeout_err); end
    step(60);
    checks++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL timeout_disabled: got %b want 0", timeout_err); end
    run = 1'b0;
    step(1);
    checks++; if (azmux_hi !== 1'b0) begin fails++; $display("FAIL abort_wait_mux: got %b want 0", azmux_hi); end
    mock_never = 1'b0;
    step(20);
  endtask

  task automatic test_abort();
    int trigs, pvs;
    trigs = 0; pvs = 0;
    az_enable = 1'b0; clk_timeout_duration = '0; mock_dur = 4;
    clk_settle_duration = CNT_W'(10);
    run = 1'b1;
    step(3);
    checks++; if (azmux_hi !== 1'b1) begin fails++; $display("FAIL abort_settle_mux: got %b want 1", azmux_hi); end
    run = 1'b0;
    step(1);
    checks++; if (azmux_hi !== 1'b0) begin fails++; $display("FAIL abort_mux: got %b want 0", azmux_hi); end
    for (int c = 0; c < 20; c++) begin
      step(1);
      if (adc_measure_trig) trigs++;
      if (phase_valid) pvs++;
    end
    checks++; if (trigs !== 0) begin fails++; $display("FAIL abort_no_trig: got %0d want 0", trigs); end
    checks++; if (pvs !== 0) begin fails++; $display("FAIL abort_no_phase_valid: got %0d want 0", pvs); end
    checks++; if (int'(sample_count) !== sc_model) begin fails++; $display("FAIL abort_count: got %0d want %0d", sample_count, sc_model); end
  endtask

  task automatic test_reset_mid_wait();
    bit trig_seen;
    trig_seen = 1'b0;
    az_enable = 1'b0; clk_timeout_duration = '0; mock_dur = 30;
    clk_settle_duration = CNT_W'(2);
    run = 1'b1;
    for (int c = 0; c < 50 && !trig_seen; c++) begin
      step(1);
      if (adc_measure_trig) trig_seen = 1'b1;
    end
    step(5);
    checks++; if (trig_seen !== 1'b1) begin fails++; $display("FAIL rst_wait_trig_seen: got %b want 1", trig_seen); end
    checks++; if (azmux_hi !== 1'b1) begin fails++; $display("FAIL rst_wait_pre_mux: got %b want 1", azmux_hi); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (azmux_hi !== 1'b0) begin fails++; $display("FAIL rst_async_mux: got %b want 0", azmux_hi); end
    checks++; if (adc_measure_trig !== 1'b0) begin fails++; $display("FAIL rst_async_trig: got %b want 0", adc_measure_trig); end
    checks++; if (phase_valid !== 1'b0) begin fails++; $display("FAIL rst_async_phase_valid: got %b want 0", phase_valid); end
    checks++; if (phase_hi !== 1'b0) begin fails++; $display("FAIL rst_async_phase_hi: got %b want 0", phase_hi); end
    checks++; if (sample_count !== '0) begin fails++; $display("FAIL rst_async_count: got %0d want 0", sample_count); end
    checks++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL rst_async_err: got %b want 0", timeout_err); end
    run = 1'b0;
    step(1);
    reset_n = 1'b1;
    sc_model = 0;
    step(40);
  endtask

  task automatic test_wrap();
    int need, seen;
    need = SCMOD - sc_model; seen = 0;
    az_enable = 1'b1; clk_timeout_duration = '0; mock_dur = 3; mock_stale = 0;
    clk_settle_duration = '0;
    run = 1'b1;
    for (int c = 0; c < 6000 && seen < need; c++) begin
      step(1);
      if (phase_valid) begin
        seen++;
        sc_model = (sc_model + 1) % SCMOD;
        checks++; if (int'(sample_count) !== sc_model) begin fails++; $display("FAIL wrap_count: got %0d want %0d", sample_count, sc_model); end
      end
    end
    run = 1'b0;
    checks++; if (seen !== need) begin fails++; $display("FAIL wrap_completions: got %0d want %0d", seen, need); end
    step(2);
    checks++; if (sample_count !== '0) begin fails++; $display("FAIL wrap_final: got %0d want 0", sample_count); end
  endtask

  initial begin
    test_reset();
    test_hi_only();
    test_auto_zero();
    test_stale_valid();
    test_timeout();
    test_abort();
    test_reset_mid_wait();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
